product_accumulator: RTL
========================

# product_accumulator

Signed multiply-accumulate back end that sits directly downstream of the 32×32 Booth multiplier and consumes its 64-bit signed products. It sums a programmed number of products into a saturating wide accumulator, giving dot-product and FIR-tap results. Products arrive over a valid/ready handshake, and the finished sum leaves over a second valid/ready handshake. A sticky overflow flag reports any saturation.

## Interface
- ACC_W, 72: accumulator width in bits. Must be 64 or more.
- LEN_W, 8: width of the product-count field.
- clk  in  1  the single clock for the block.
- rst_n  in  1  reset. Asynchronous and active-low.
- start  in  1  request a new accumulation. Sampled only in IDLE.
- len  in  LEN_W  number of products to accumulate. Sampled together with start.
- prod_valid  in  1  a product is presented on prod.
- prod  in  64  signed two's-complement product from the multiplier.
- prod_ready  out  1  the block accepts a product this cycle.
- busy  out  1  the block is not in IDLE.
- out_valid  out  1  acc_out and ovf are valid.
- out_ready  in  1  the consumer accepts the result.
- acc_out  out  ACC_W  signed accumulated sum.
- ovf  out  1  sticky flag: at least one addition saturated in this run.

## Operation
- States and transitions:
  - IDLE. If start=1 and len≠0, go to ACCUM. If start=1 and len=0, go to DONE.
  - ACCUM. Go to DONE on the beat that accepts the len-th product.
  - DONE. Go to IDLE when out_valid and out_ready are both 1.
- Start behaviour:
  - On start, clear the accumulator to 0, clear ovf, and load the remaining-count register with len.
  - start is ignored in ACCUM and DONE.
- Product beats:
  - prod_ready=1 only in ACCUM.
  - A beat happens when prod_valid and prod_ready are both 1.
  - On each beat, sign-extend prod to ACC_W+1 bits, add it to the sign-extended accumulator, and decrement the remaining count.
- Saturation:
  - If the (ACC_W+1)-bit sum is above 2^(ACC_W−1)−1, the accumulator takes that value (max positive).
  - If the sum is below −2^(ACC_W−1), the accumulator takes that value (max negative).
  - In either case ovf is set and stays set until the next start.
- Once saturated, the accumulator keeps accumulating from the saturated value. It does not freeze.
- acc_out always shows the accumulator register.
- out_valid=1 only in DONE.
- acc_out and ovf are held stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: state=IDLE, accumulator=0, count=0, prod_ready=0, busy=0, out_valid=0, acc_out=0, ovf=0.
- Reset mid-run (rst_n low in any state) clears all state asynchronously. Any partial sum is discarded.
- start high at edge N gives busy=1 and prod_ready=1 from cycle N+1.
- A product accepted at edge K appears in acc_out after edge K.
- After the last beat at edge K: out_valid=1 and prod_ready=0 from cycle K+1. So result latency is 1 cycle after the final beat.
- len=0: out_valid=1 in the cycle after start, with acc_out=0 and ovf=0.
- prod_valid with gaps (bubbles) is allowed. The count decrements only on beats.
- Output handshake: with out_ready=1 at edge M in DONE, the state is IDLE at M+1. A new start is accepted at M+1 at the earliest.
- There are no combinational paths from inputs to outputs. prod_ready, busy and out_valid all decode directly from state.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE, ACCUM, DONE);
  - the PROD_W=64 constant;
  - the ACC_W and LEN_W defaults.
- One sub-module, sat_adder: purely combinational. Inputs are the (ACC_W)-bit accumulator and the 64-bit product. Outputs are the saturated ACC_W-bit sum and an overflow bit.
- The top level holds the FSM, the count register, the accumulator register, the ovf register and the handshake logic.

## Test plan
- Basic run: start with len=3; products 5, −2, 100 sent back-to-back. Required: acc_out=103, ovf=0, out_valid 1 cycle after the third beat.
- Bubbles and backpressure: len=2 with prod_valid gaps, then out_ready held low 4 cycles. Required: result stable and out_valid held for all 4 cycles; return to IDLE the cycle after out_ready=1.
- Saturation: ACC_W=64, len=2, products 0x7FFF_FFFF_FFFF_FFFF and 1. Required: acc_out=0x7FFF_FFFF_FFFF_FFFF, ovf=1. Negative case: −2^63 plus −1 gives acc_out=−2^63, ovf=1.
- len=0: start with len=0 gives out_valid next cycle, acc_out=0, ovf=0, and prod_ready stays 0 throughout.
- Ignored start and reset: start pulsed mid-ACCUM has no effect on the count or the sum. Asserting rst_n=0 after 2 of 5 products gives all outputs at reset values immediately, with no out_valid afterwards.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the product accumulator datapath.
// Covers the FSM state encoding, the multiplier product width and the default sizing.
package mult_pkg;

  localparam int unsigned PROD_W    = 64;
  localparam int unsigned ACC_W_DEF = 72;
  localparam int unsigned LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / result-out handshake bundle for product_accumulator.
// The master side is the upstream driver and result consumer; the slave side is the accumulator.
interface product_accumulator_if
  import mult_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
);

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              prod_ready;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;

  modport master (
    output start,
    output len,
    output prod_valid,
    output prod,
    output out_ready,
    input  prod_ready,
    input  busy,
    input  out_valid,
    input  acc_out,
    input  ovf
  );

  modport slave (
    input  start,
    input  len,
    input  prod_valid,
    input  prod,
    input  out_ready,
    output prod_ready,
    output busy,
    output out_valid,
    output acc_out,
    output ovf
  );

endinterface

// File: rtl/sat_adder.sv
// Combinational saturating adder: signed ACC_W-bit accumulator plus signed 64-bit product.
// The sum is formed one bit wider than the accumulator, then clamped on overflow.
module sat_adder
  import mult_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  localparam int unsigned ExtW = ACC_W + 1 - PROD_W;

  logic [ACC_W:0] w_acc_ext;
  logic [ACC_W:0] w_prod_ext;
  logic [ACC_W:0] w_sum;

  assign w_acc_ext  = {i_acc[ACC_W-1], i_acc};
  assign w_prod_ext = {{ExtW{i_prod[PROD_W-1]}}, i_prod};
  assign w_sum      = w_acc_ext + w_prod_ext;

  // Top two bits disagree exactly when the wide sum is outside the ACC_W-bit signed range.
  assign o_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    o_sum = w_sum[ACC_W-1:0];
    if (o_ovf) begin
      o_sum = {w_sum[ACC_W], {(ACC_W - 1){~w_sum[ACC_W]}}};
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Saturating multiply-accumulate back end: sums len signed products, then presents the result.
// Handshake outputs decode straight from state, so there is no input-to-output combinational path.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  product_accumulator_if.slave  bus
);

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("product_accumulator: ACC_W must be at least PROD_W");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;

  logic             w_beat;
  logic [ACC_W-1:0] w_sum;
  logic             w_sum_ovf;

  sat_adder #(
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .i_acc  (r_acc),
    .i_prod (bus.prod),
    .o_sum  (w_sum),
    .o_ovf  (w_sum_ovf)
  );

  assign w_beat = bus.prod_valid && (r_state == StAccum);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_acc_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_count_nxt = bus.len;
          w_state_nxt = (bus.len != '0) ? StAccum : StDone;
        end
      end
      StAccum: begin
        if (w_beat) begin
          // Saturated values keep accumulating; only the flag is sticky.
          w_acc_nxt   = w_sum;
          w_ovf_nxt   = r_ovf | w_sum_ovf;
          w_count_nxt = r_count - 1'b1;
          if (r_count == LEN_W'(1)) begin
            w_state_nxt = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_count <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign bus.prod_ready = (r_state == StAccum);
  assign bus.busy       = (r_state != StIdle);
  assign bus.out_valid  = (r_state == StDone);
  assign bus.acc_out    = r_acc;
  assign bus.ovf        = r_ovf;

endmodule
